// File: rtl/airlock_sequencer_pkg.sv
// Shared constants and types for the airlock interlock controller.
package airlock_sequencer_pkg;

    localparam int unsigned COUNT_W   = 10;
    localparam int unsigned COUNT_MAX = 1023;

    localparam int unsigned DEF_TICK_DIV    = 96;
    localparam int unsigned DEF_FILL_SECS   = 7;
    localparam int unsigned DEF_EVAC_SECS   = 8;
    localparam int unsigned DEF_SIGNAL_SECS = 5;

    typedef enum logic [1:0] {
        ST_EVACUATED   = 2'd0,
        ST_FILLING     = 2'd1,
        ST_PRESSURIZED = 2'd2,
        ST_EVACUATING  = 2'd3
    } chamber_state_e;

    // Chamber requests in priority order, highest first.
    typedef struct packed {
        logic fill;
        logic evac;
        logic inner;
        logic outer;
    } chamber_req_t;

endpackage

// File: rtl/airlock_sequencer_sec_countdown.sv
// Seconds countdown: loads a value, steps down once per TICK_DIV cycles, holds at 0.
module airlock_sequencer_sec_countdown
    import airlock_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [COUNT_W-1:0] load_value_i,
    output logic [COUNT_W-1:0] count_o,
    output logic               done_c
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               tick_c;

    // Prescaler only runs while there is something left to count.
    assign tick_c = (count_q != '0) && (presc_q == PRESC_W'(TICK_DIV - 1));

    // Next count/prescaler; a load always wins over a decrement.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        if (load_i) begin
            presc_d = '0;
            count_d = load_value_i;
        end else if (tick_c) begin
            presc_d = '0;
            count_d = count_q - COUNT_W'(1);
        end else if (count_q != '0) begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // Count and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            count_q <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign done_c  = tick_c && (count_q == COUNT_W'(1)) && !load_i;

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock interlock controller: port state, chamber fill/evacuate FSM and countdowns.
module airlock_sequencer
    import airlock_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
    parameter int unsigned FILL_SECS   = DEF_FILL_SECS,
    parameter int unsigned EVAC_SECS   = DEF_EVAC_SECS,
    parameter int unsigned SIGNAL_SECS = DEF_SIGNAL_SECS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               outer_flip_i,
    input  logic               inner_flip_i,
    input  logic               fill_req_i,
    input  logic               evac_req_i,
    input  logic               signal_req_i,
    output logic               outer_closed_o,
    output logic               inner_closed_o,
    output logic               pressurized_o,
    output logic               evacuated_o,
    output logic               busy_o,
    output logic               reject_o,
    output logic [COUNT_W-1:0] count_chamber_o,
    output logic [COUNT_W-1:0] count_signal_o
);

    // Durations must fit the 10-bit display counts.
    if (TICK_DIV < 1 || FILL_SECS > COUNT_MAX || EVAC_SECS > COUNT_MAX ||
        SIGNAL_SECS > COUNT_MAX) begin : g_param_check
        $error("airlock_sequencer: parameter out of range");
    end

    chamber_state_e     state_q, state_d;
    logic               outer_q, outer_d;
    logic               inner_q, inner_d;
    logic               press_q, press_d;
    logic               evac_q, evac_d;
    logic               busy_q, busy_d;
    logic               reject_q, reject_d;
    chamber_req_t       req_c, acc_c;
    logic               ch_load_c;
    logic [COUNT_W-1:0] ch_value_c;
    logic               ch_done_c;
    logic               sig_done_unused_c;

    assign req_c = '{fill: fill_req_i, evac: evac_req_i, inner: inner_flip_i, outer: outer_flip_i};

    // Request arbitration, port toggles and chamber state transitions.
    always_comb begin
        state_d    = state_q;
        outer_d    = outer_q;
        inner_d    = inner_q;
        acc_c      = '0;
        unique case (state_q)
            ST_EVACUATED: begin
                if (req_c.fill && outer_q && inner_q) begin
                    acc_c.fill = 1'b1;
                    state_d    = ST_FILLING;
                end else if (req_c.outer) begin
                    acc_c.outer = 1'b1;
                    outer_d     = !outer_q;
                end
            end
            ST_PRESSURIZED: begin
                if (req_c.evac && outer_q && inner_q) begin
                    acc_c.evac = 1'b1;
                    state_d    = ST_EVACUATING;
                end else if (req_c.inner) begin
                    acc_c.inner = 1'b1;
                    inner_d     = !inner_q;
                end
            end
            ST_FILLING:    if (ch_done_c) state_d = ST_PRESSURIZED;
            ST_EVACUATING: if (ch_done_c) state_d = ST_EVACUATED;
            default:       state_d = ST_EVACUATED;
        endcase
        reject_d   = |(4'(req_c) & ~4'(acc_c));
        press_d    = (state_d == ST_PRESSURIZED);
        evac_d     = (state_d == ST_EVACUATED);
        busy_d     = (state_d == ST_FILLING) || (state_d == ST_EVACUATING);
        ch_load_c  = acc_c.fill || acc_c.evac;
        ch_value_c = acc_c.evac ? COUNT_W'(EVAC_SECS) : COUNT_W'(FILL_SECS);
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EVACUATED;
            outer_q  <= 1'b1;
            inner_q  <= 1'b1;
            press_q  <= 1'b0;
            evac_q   <= 1'b1;
            busy_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            outer_q  <= outer_d;
            inner_q  <= inner_d;
            press_q  <= press_d;
            evac_q   <= evac_d;
            busy_q   <= busy_d;
            reject_q <= reject_d;
        end
    end

    airlock_sequencer_sec_countdown #(.TICK_DIV(TICK_DIV)) u_chamber_countdown (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (ch_load_c),
        .load_value_i (ch_value_c),
        .count_o      (count_chamber_o),
        .done_c       (ch_done_c)
    );

    airlock_sequencer_sec_countdown #(.TICK_DIV(TICK_DIV)) u_signal_countdown (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (signal_req_i),
        .load_value_i (COUNT_W'(SIGNAL_SECS)),
        .count_o      (count_signal_o),
        .done_c       (sig_done_unused_c)
    );

    assign outer_closed_o = outer_q;
    assign inner_closed_o = inner_q;
    assign pressurized_o  = press_q;
    assign evacuated_o    = evac_q;
    assign busy_o         = busy_q;
    assign reject_o       = reject_q;

endmodule
